// File: rtl/edge_delay_trigger_pkg.sv
// Shared definitions for the edge-to-delayed-trigger generator.
// Per-channel state encoding lives here so the channel and any monitors agree on it.
package edge_delay_trigger_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/edge_delay_trigger_chan.sv
// One channel: rising-edge detect on enable, programmable delay counter and
// IDLE/WAIT/HOLD state machine driving a registered trigger and busy flag.
module edge_delay_trigger_chan
    import edge_delay_trigger_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter bit          RETRIGGER  = 1'b0,
    parameter bit          PULSE_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] delay,
    output logic             trigger,
    output logic             busy,
    output logic             fire_evt
);

    logic             en_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             edge_det;
    logic             retrig;
    logic [CNT_W-1:0] load_val;

    assign edge_det = enable & ~en_q;
    assign retrig   = edge_det & RETRIGGER;
    // A delay of 0 behaves as 1, so the reload never underflows.
    assign load_val = (delay == '0) ? '0 : delay - CNT_W'(1);

    // Trigger-assert event for this cycle; a retrigger in the terminal cycle wins.
    assign fire_evt = (state_q == ST_WAIT) && (cnt_q == '0) && !retrig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            trigger <= 1'b0;
            busy    <= 1'b0;
        end else begin
            en_q <= enable;
            case (state_q)
                ST_IDLE: begin
                    if (edge_det) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= load_val;
                        trigger <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (retrig) begin
                        cnt_q <= load_val;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_HOLD;
                        trigger <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (edge_det) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= load_val;
                        trigger <= 1'b0;
                        busy    <= 1'b1;
                    end else if (PULSE_MODE) begin
                        state_q <= ST_IDLE;
                        trigger <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/edge_delay_trigger.sv
// Multi-channel edge-to-delayed-trigger generator: independent channels plus a
// registered fire strobe that flags any channel asserting its trigger.
module edge_delay_trigger
    import edge_delay_trigger_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 8,
    parameter bit          RETRIGGER  = 1'b0,
    parameter bit          PULSE_MODE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS*CNT_W-1:0] delay,
    output logic [CHANNELS-1:0]       trigger,
    output logic [CHANNELS-1:0]       busy,
    output logic                      fire
);

    logic [CHANNELS-1:0] fire_evt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_delay_trigger_chan #(
            .CNT_W      (CNT_W),
            .RETRIGGER  (RETRIGGER),
            .PULSE_MODE (PULSE_MODE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable[i]),
            .delay    (delay[i*CNT_W +: CNT_W]),
            .trigger  (trigger[i]),
            .busy     (busy[i]),
            .fire_evt (fire_evt[i])
        );
    end

    // Registered on the same edge as the channel trigger, so fire lines up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire <= 1'b0;
        end else begin
            fire <= |fire_evt;
        end
    end

endmodule

// File: tb/tb_edge_delay_trigger.sv
// Runs four parameter variants side by side on shared stimulus and compares each
// against a deadline-based reference model every cycle.
module tb_edge_delay_trigger;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned NCFG = 4; // bit0 = RETRIGGER, bit1 = PULSE_MODE

    logic              clk;
    logic              rst;
    logic [CH-1:0]     enable;
    logic [CH*CW-1:0]  delay;
    logic [CH-1:0]     trig_w [NCFG];
    logic [CH-1:0]     busy_w [NCFG];
    logic              fire_w [NCFG];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        edge_delay_trigger #(
            .CHANNELS   (CH),
            .CNT_W      (CW),
            .RETRIGGER  ((g % 2) == 1),
            .PULSE_MODE ((g / 2) == 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .delay   (delay),
            .trigger (trig_w[g]),
            .busy    (busy_w[g]),
            .fire    (fire_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each channel either has a pending deadline or not.
    bit              pend [NCFG][CH];
    longint unsigned due  [NCFG][CH];
    bit              trg  [NCFG][CH];
    bit              fr   [NCFG];
    logic [CH-1:0]   prev_en;
    longint unsigned t;

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            fr[c] = 1'b0;
            for (int i = 0; i < CH; i++) begin
                pend[c][i] = 1'b0;
                due[c][i]  = 0;
                trg[c][i]  = 1'b0;
            end
        end
        prev_en = '1;
    endtask

    task automatic model_step(input logic [CH-1:0] en, input logic [CH*CW-1:0] dly);
        for (int c = 0; c < NCFG; c++) begin
            bit ret;
            bit pul;
            ret   = (c % 2) == 1;
            pul   = (c / 2) == 1;
            fr[c] = 1'b0;
            for (int i = 0; i < CH; i++) begin
                bit              e;
                longint unsigned d;
                e = en[i] && !prev_en[i];
                d = dly[i*CW +: CW];
                if (d == 0) d = 1;
                if (pend[c][i]) begin
                    if (e && ret) begin
                        due[c][i] = t + d;
                    end else if (t == due[c][i]) begin
                        pend[c][i] = 1'b0;
                        trg[c][i]  = 1'b1;
                        fr[c]      = 1'b1;
                    end
                end else if (e) begin
                    pend[c][i] = 1'b1;
                    due[c][i]  = t + d;
                    trg[c][i]  = 1'b0;
                end else if (pul) begin
                    trg[c][i] = 1'b0;
                end
            end
        end
        prev_en = en;
        t++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_all(input string phase);
        for (int c = 0; c < NCFG; c++) begin
            logic [CH-1:0] et;
            logic [CH-1:0] eb;
            for (int i = 0; i < CH; i++) begin
                et[i] = trg[c][i];
                eb[i] = pend[c][i];
            end
            chk($sformatf("%s trigger cfg%0d", phase, c), 32'(trig_w[c]), 32'(et));
            chk($sformatf("%s busy cfg%0d", phase, c), 32'(busy_w[c]), 32'(eb));
            chk($sformatf("%s fire cfg%0d", phase, c), 32'(fire_w[c]), 32'(fr[c]));
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next.
    task automatic cycle(input string phase, input logic [CH-1:0] en,
                         input logic [CH*CW-1:0] dly);
        enable = en;
        delay  = dly;
        @(posedge clk);
        model_step(en, dly);
        #1;
        check_all(phase);
    endtask

    task automatic idle_cycles(input string phase, input int n, input logic [CH*CW-1:0] dly);
        for (int k = 0; k < n; k++) cycle(phase, '0, dly);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string phase, input int n, input logic [CH-1:0] en);
        enable = en;
        rst    = 1'b1;
        #1;
        model_reset();
        check_all(phase);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_all(phase);
        end
        rst = 1'b0;
    endtask

    logic [CH*CW-1:0] d5;
    logic [CH*CW-1:0] d_mix;
    logic [CH*CW-1:0] d_alt;

    initial begin
        rst    = 1'b1;
        enable = '0;
        delay  = '0;
        t      = 0;
        model_reset();
        d5    = {4{8'd5}};
        d_mix = {8'd255, 8'd0, 8'd7, 8'd3};
        d_alt = {8'd1, 8'd9, 8'd2, 8'd20};

        @(posedge clk);
        #1;
        do_reset("reset", 2, '0);

        // Single edge then a second edge 10 clocks later.
        idle_cycles("pre", 3, d5);
        cycle("edge1", 4'b0001, d5);
        idle_cycles("wait1", 9, d5);
        cycle("edge2", 4'b0001, d5);
        idle_cycles("wait2", 9, d5);

        // Second edge at t0+3 exercises retrigger versus ignore.
        cycle("rt_e1", 4'b0011, d5);
        idle_cycles("rt_gap", 2, d5);
        cycle("rt_e2", 4'b0011, d5);
        idle_cycles("rt_wait", 10, d5);

        // Delay 0 and delay 1 both give a one-cycle latency.
        cycle("d0_edge", 4'b1111, '0);
        idle_cycles("d0_wait", 4, '0);
        cycle("d1_edge", 4'b1111, {4{8'd1}});
        idle_cycles("d1_wait", 4, {4{8'd1}});

        // Reset mid-count, enable held high through release, then a real edge.
        cycle("rs_edge", 4'b1111, d5);
        cycle("rs_hold", 4'b1111, d5);
        do_reset("rs_mid", 2, 4'b1111);
        for (int k = 0; k < 10; k++) cycle("rs_high", 4'b1111, d5);
        cycle("rs_low", 4'b0000, d5);
        cycle("rs_edge2", 4'b1111, d5);
        idle_cycles("rs_wait", 8, d5);

        // Mixed delays together; delay input changes mid-count.
        cycle("mix_edge", 4'b1111, d_mix);
        idle_cycles("mix_wait", 262, d_alt);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic [CH-1:0]    en;
            logic [CH*CW-1:0] dly;
            en = enable;
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) en[i] = ~en[i];
                if ($urandom_range(0, 15) == 0) dly[i*CW +: CW] = CW'($urandom_range(0, 255));
                else dly[i*CW +: CW] = CW'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 599) == 0) do_reset("rnd_rst", 1, en);
            else cycle("rnd", en, dly);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
